mdu_seq: RTL and testbench

- Multi-cycle RV32M multiply/divide unit; the responder end of the EX-stage operand/select interface.
- The EX stage issues DATA1/DATA2 with an ALU select code in the M range, stalls on BUSY, and takes RESULT when DONE pulses.
- Replaces single-cycle combinational mul/div paths; one shared 32-iteration datapath covers all eight M ops.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/mdu_iter_step.sv | 40 ++++
 rtl/mdu_seq.sv | 161 ++++++++++++++++
 tb/tb_mdu_seq.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: M-extension select codes, MDU state encoding and
// the fixed results used for the divide special cases.
package alu_pkg;

  localparam int XLEN = 32;

  localparam logic [4:0] SEL_MUL    = 5'b01001;
  localparam logic [4:0] SEL_MULH   = 5'b01010;
  localparam logic [4:0] SEL_MULHU  = 5'b01011;
  localparam logic [4:0] SEL_MULHSU = 5'b01100;
  localparam logic [4:0] SEL_DIV    = 5'b01101;
  localparam logic [4:0] SEL_DIVU   = 5'b01110;
  localparam logic [4:0] SEL_REM    = 5'b01111;
  localparam logic [4:0] SEL_REMU   = 5'b10000;

  localparam logic [XLEN-1:0] DIV0_Q  = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } mdu_state_e;

  function automatic logic isMOp(input logic [4:0] sel);
    return sel inside {SEL_MUL, SEL_MULH, SEL_MULHU, SEL_MULHSU,
                       SEL_DIV, SEL_DIVU, SEL_REM, SEL_REMU};
  endfunction

  function automatic logic isDivOp(input logic [4:0] sel);
    return sel inside {SEL_DIV, SEL_DIVU, SEL_REM, SEL_REMU};
  endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One combinational iteration of the shared multiply/divide datapath.
// Multiply shifts {hi,lo} right after a conditional add; divide shifts left.
module mdu_iter_step
  import alu_pkg::*;
(
  input  logic            isDiv_i,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] opb_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] diff;
  logic            unused_diffMsb;

  // A successful trial subtract leaves a value below the divisor, so bit XLEN is always zero.
  assign unused_diffMsb = diff[XLEN];

  always_comb begin
    sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opb_i} : '0);
    shifted = {hi_i, lo_i[XLEN-1]};
    diff    = {1'b0, shifted} - {2'b00, opb_i};
    if (isDiv_i) begin
      if (diff[XLEN+1]) begin
        hi_o = shifted[XLEN-1:0];
        lo_o = {lo_i[XLEN-2:0], 1'b0};
      end else begin
        hi_o = diff[XLEN-1:0];
        lo_o = {lo_i[XLEN-2:0], 1'b1};
      end
    end else begin
      hi_o = sum[XLEN:1];
      lo_o = {sum[0], lo_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle RV32M multiply/divide unit: operates on magnitudes for 32 CALC
// cycles, then applies sign correction and result select in FIX.
module mdu_seq #(
  parameter int unsigned XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  input  logic [4:0]      SELECT,
  input  logic            FLUSH,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT
);
  import alu_pkg::*;

  mdu_state_e        state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [4:0]        op_q, op_d;
  logic              negQuot_q, negQuot_d;
  logic              negRem_q, negRem_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic [XLEN-1:0]   stepHi, stepLo;
  logic              signA, signB, accept, special;
  logic [XLEN-1:0]   magA, magB, specialResult;
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]   quot, rem;

  mdu_iter_step u_step (
    .isDiv_i (isDivOp(op_q)),
    .hi_i    (hi_q),
    .lo_i    (lo_q),
    .opb_i   (opb_q),
    .hi_o    (stepHi),
    .lo_o    (stepLo)
  );

  // DONE has BUSY low, so a new request may be taken straight out of DONE.
  always_comb begin
    signA   = DATA1[XLEN-1] && (SELECT inside {SEL_MULH, SEL_MULHSU, SEL_DIV, SEL_REM});
    signB   = DATA2[XLEN-1] && (SELECT inside {SEL_MULH, SEL_DIV, SEL_REM});
    magA    = signA ? -DATA1 : DATA1;
    magB    = signB ? -DATA2 : DATA2;
    accept  = START && !FLUSH && isMOp(SELECT) &&
              (state_q == S_IDLE || state_q == S_DONE);
    special       = 1'b0;
    specialResult = '0;
    if (isDivOp(SELECT)) begin
      if (DATA2 == '0) begin
        special       = 1'b1;
        specialResult = (SELECT inside {SEL_DIV, SEL_DIVU}) ? DIV0_Q : DATA1;
      end else if ((SELECT inside {SEL_DIV, SEL_REM}) && DATA1 == INT_MIN && DATA2 == '1) begin
        special       = 1'b1;
        specialResult = (SELECT == SEL_DIV) ? INT_MIN : '0;
      end
    end
  end

  always_comb begin
    product = {hi_q, lo_q};
    if (negQuot_q) begin
      product = -product;
    end
    quot = negQuot_q ? -lo_q : lo_q;
    rem  = negRem_q ? -hi_q : hi_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    negQuot_d = negQuot_q;
    negRem_d  = negRem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opb_d     = opb_q;
    result_d  = result_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          op_d      = SELECT;
          negQuot_d = signA ^ signB;
          negRem_d  = signA;
          cnt_d     = '0;
          hi_d      = '0;
          if (isDivOp(SELECT)) begin
            lo_d  = magA;
            opb_d = magB;
          end else begin
            lo_d  = magB;
            opb_d = magA;
          end
          if (special) begin
            result_d = specialResult;
            state_d  = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        hi_d  = stepHi;
        lo_d  = stepLo;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        case (op_q)
          SEL_MUL:                         result_d = product[XLEN-1:0];
          SEL_MULH, SEL_MULHU, SEL_MULHSU: result_d = product[2*XLEN-1:XLEN];
          SEL_DIV, SEL_DIVU:               result_d = quot;
          default:                         result_d = rem;
        endcase
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    if (FLUSH) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      negQuot_q <= 1'b0;
      negRem_q  <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      opb_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      negQuot_q <= negQuot_d;
      negRem_q  <= negRem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opb_q     <= opb_d;
      result_q  <= result_d;
    end
  end

  assign BUSY   = (state_q == S_CALC) || (state_q == S_FIX);
  assign DONE   = (state_q == S_DONE);
  assign RESULT = result_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed spec cases plus randomized ops
// compared against a plain-arithmetic RV32M reference model.
module tb_mdu_seq;

  localparam logic [4:0] T_MUL    = 5'b01001;
  localparam logic [4:0] T_MULH   = 5'b01010;
  localparam logic [4:0] T_MULHU  = 5'b01011;
  localparam logic [4:0] T_MULHSU = 5'b01100;
  localparam logic [4:0] T_DIV    = 5'b01101;
  localparam logic [4:0] T_DIVU   = 5'b01110;
  localparam logic [4:0] T_REM    = 5'b01111;
  localparam logic [4:0] T_REMU   = 5'b10000;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        START = 1'b0;
  logic [31:0] DATA1 = '0;
  logic [31:0] DATA2 = '0;
  logic [4:0]  SELECT = '0;
  logic        FLUSH = 1'b0;
  logic        BUSY, DONE;
  logic [31:0] RESULT;

  int checks = 0;
  int errors = 0;

  mdu_seq #(.XLEN(32)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .DATA1(DATA1), .DATA2(DATA2),
    .SELECT(SELECT), .FLUSH(FLUSH), .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] refModel(input logic [4:0] sel, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [63:0] uProd;
    longint      sProd;
    uProd = {32'd0, a} * {32'd0, b};
    sProd = 0;
    case (sel)
      T_MUL:    return uProd[31:0];
      T_MULHU:  return uProd[63:32];
      T_MULH: begin
        sProd = longint'($signed(a)) * longint'($signed(b));
        return sProd[63:32];
      end
      T_MULHSU: begin
        sProd = longint'($signed(a)) * longint'({32'd0, b});
        return sProd[63:32];
      end
      T_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return $signed(a) / $signed(b);
      end
      T_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
      T_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      T_REMU: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int refLatency(input logic [4:0] sel, input logic [31:0] a,
                                    input logic [31:0] b);
    if ((sel inside {T_DIV, T_DIVU, T_REM, T_REMU}) && b == 0) return 1;
    if ((sel inside {T_DIV, T_REM}) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issues one request in the current cycle; cycle 1 follows the accept edge.
  task automatic run_op(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int busyCnt,
                        output logic busyAtDone);
    SELECT = sel; DATA1 = a; DATA2 = b; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    lat = -1; busyCnt = 0; busyAtDone = 1'b0; res = RESULT;
    for (int c = 1; c <= 40; c++) begin
      if (DONE) begin
        lat = c; res = RESULT; busyAtDone = BUSY;
        break;
      end
      if (BUSY) busyCnt++;
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (BUSY !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", BUSY); end
    checks++; if (DONE !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", DONE); end
    checks++; if (RESULT !== 32'd0) begin errors++; $display("[TB] FAIL reset_result: got %h expected 00000000", RESULT); end
    RESET = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_directed();
    logic [4:0]  dSel [12];
    logic [31:0] dA [12], dB [12], dExp [12];
    int          dLat [12];
    logic [31:0] res; int lat, busyCnt; logic busyAtDone;
    dSel = '{T_MUL, T_MULH, T_MULHU, T_MULHSU, T_DIV, T_REM, T_DIVU, T_REMU,
             T_DIV, T_REM, T_DIV, T_REM};
    dA   = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
             32'd100, 32'd100, 32'd5, 32'd5, 32'h80000000, 32'h80000000};
    dB   = '{32'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd2, 32'd7, 32'd7,
             32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    dExp = '{32'h2A, 32'h0, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF,
             32'd14, 32'd2, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
    dLat = '{34, 34, 34, 34, 34, 34, 34, 34, 1, 1, 1, 1};
    for (int i = 0; i < 12; i++) begin
      run_op(dSel[i], dA[i], dB[i], res, lat, busyCnt, busyAtDone);
      checks++; if (res !== dExp[i]) begin errors++; $display("[TB] FAIL directed_result[%0d]: got %h expected %h", i, res, dExp[i]); end
      checks++; if (lat != dLat[i]) begin errors++; $display("[TB] FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, dLat[i]); end
      if (i == 0) begin
        checks++; if (busyCnt != 33) begin errors++; $display("[TB] FAIL mul_busy_cycles: got %0d expected 33", busyCnt); end
        checks++; if (busyAtDone !== 1'b0) begin errors++; $display("[TB] FAIL mul_busy_at_done: got %b expected 0", busyAtDone); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res; int lat, busyCnt; logic busyAtDone;
    run_op(T_MUL, 32'd12, 32'd11, res, lat, busyCnt, busyAtDone);
    checks++; if (res !== 32'd132) begin errors++; $display("[TB] FAIL b2b_first: got %h expected %h", res, 32'd132); end
    run_op(T_DIVU, 32'd50, 32'd5, res, lat, busyCnt, busyAtDone);
    checks++; if (res !== 32'd10) begin errors++; $display("[TB] FAIL b2b_second: got %h expected %h", res, 32'd10); end
    checks++; if (lat != 34) begin errors++; $display("[TB] FAIL b2b_latency: got %0d expected 34", lat); end
  endtask

  task automatic test_random();
    logic [4:0]  selTable [8];
    logic [4:0]  sel; logic [31:0] a, b, exp, res;
    int lat, busyCnt; logic busyAtDone;
    selTable = '{T_MUL, T_MULH, T_MULHU, T_MULHSU, T_DIV, T_DIVU, T_REM, T_REMU};
    for (int i = 0; i < 40; i++) begin
      sel = selTable[$urandom_range(0, 7)];
      a = pickOperand();
      b = pickOperand();
      exp = refModel(sel, a, b);
      run_op(sel, a, b, res, lat, busyCnt, busyAtDone);
      checks++; if (res !== exp) begin errors++; $display("[TB] FAIL random_result sel=%b a=%h b=%h: got %h expected %h", sel, a, b, res, exp); end
      checks++; if (lat != refLatency(sel, a, b)) begin errors++; $display("[TB] FAIL random_latency sel=%b: got %0d expected %0d", sel, lat, refLatency(sel, a, b)); end
    end
  endtask

  task automatic test_flush();
    logic [31:0] res; int lat, busyCnt; logic busyAtDone; logic sawDone;
    run_op(T_MUL, 32'd5, 32'd5, res, lat, busyCnt, busyAtDone);
    checks++; if (res !== 32'd25) begin errors++; $display("[TB] FAIL flush_setup: got %h expected %h", res, 32'd25); end
    SELECT = T_DIVU; DATA1 = 32'd1000; DATA2 = 32'd7; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    sawDone = 1'b0;
    for (int c = 1; c < 10; c++) begin
      if (DONE) sawDone = 1'b1;
      @(posedge CLK); #1;
    end
    if (DONE) sawDone = 1'b1;
    FLUSH = 1'b1;
    @(posedge CLK); #1;
    FLUSH = 1'b0;
    checks++; if (BUSY !== 1'b0) begin errors++; $display("[TB] FAIL flush_busy: got %b expected 0", BUSY); end
    checks++; if (DONE !== 1'b0 || sawDone) begin errors++; $display("[TB] FAIL flush_done: got %b expected 0", DONE | sawDone); end
    checks++; if (RESULT !== 32'd25) begin errors++; $display("[TB] FAIL flush_result_held: got %h expected %h", RESULT, 32'd25); end
    run_op(T_MUL, 32'd3, 32'd3, res, lat, busyCnt, busyAtDone);
    checks++; if (res !== 32'd9) begin errors++; $display("[TB] FAIL flush_next_result: got %h expected %h", res, 32'd9); end
    checks++; if (lat != 34) begin errors++; $display("[TB] FAIL flush_next_latency: got %0d expected 34", lat); end
  endtask

  task automatic test_invalid_select();
    logic sawActivity;
    SELECT = 5'b00001; DATA1 = 32'd4; DATA2 = 32'd4; START = 1'b1;
    sawActivity = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge CLK); #1;
      if (BUSY || DONE) sawActivity = 1'b1;
    end
    START = 1'b0;
    checks++; if (sawActivity) begin errors++; $display("[TB] FAIL invalid_select: got activity 1 expected 0"); end
  endtask

  task automatic test_start_while_busy();
    logic [31:0] res; int lat;
    SELECT = T_DIVU; DATA1 = 32'd1000; DATA2 = 32'd3; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    lat = -1; res = RESULT;
    for (int c = 1; c <= 40; c++) begin
      if (DONE) begin lat = c; res = RESULT; break; end
      if (c == 5) begin START = 1'b1; SELECT = T_MUL; DATA1 = 32'd9; DATA2 = 32'd9; end
      if (c == 30) START = 1'b0;
      @(posedge CLK); #1;
    end
    START = 1'b0;
    checks++; if (res !== 32'd333) begin errors++; $display("[TB] FAIL busy_start_result: got %h expected %h", res, 32'd333); end
    checks++; if (lat != 34) begin errors++; $display("[TB] FAIL busy_start_latency: got %0d expected 34", lat); end
  endtask

  task automatic test_reset_mid_op();
    logic sawDone;
    @(posedge CLK); #1;
    SELECT = T_MUL; DATA1 = 32'h1234; DATA2 = 32'h5678; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (19) begin @(posedge CLK); #1; end
    RESET = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b1;
    checks++; if (BUSY !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy: got %b expected 0", BUSY); end
    checks++; if (DONE !== 1'b0) begin errors++; $display("[TB] FAIL midreset_done: got %b expected 0", DONE); end
    checks++; if (RESULT !== 32'd0) begin errors++; $display("[TB] FAIL midreset_result: got %h expected 00000000", RESULT); end
    sawDone = 1'b0;
    for (int c = 0; c < 45; c++) begin
      @(posedge CLK); #1;
      if (DONE) sawDone = 1'b1;
    end
    checks++; if (sawDone) begin errors++; $display("[TB] FAIL midreset_no_done: got 1 expected 0"); end
  endtask

  initial begin
    $display("[TB] mdu_seq bench starting");
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_flush();
    test_invalid_select();
    test_start_while_busy();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
